// File: rtl/sevenseg_pkg.sv
// Fixed-width items shared by the seven-segment scan controller:
// segment vector type and the active-low hex glyph table.
package sevenseg_pkg;

   localparam int SEG_W = 7;

   typedef logic [SEG_W-1:0] seg_t;

   // Glyphs as {a,b,c,d,e,f,g}, active-low (0 = segment on).
   function automatic seg_t hex_to_seg_n(input logic [3:0] h);
      case (h)
         4'h0:    return 7'b0000001;
         4'h1:    return 7'b1001111;
         4'h2:    return 7'b0010010;
         4'h3:    return 7'b0000110;
         4'h4:    return 7'b1001100;
         4'h5:    return 7'b0100100;
         4'h6:    return 7'b0100000;
         4'h7:    return 7'b0001111;
         4'h8:    return 7'b0000000;
         4'h9:    return 7'b0000100;
         4'hA:    return 7'b0001000;
         4'hB:    return 7'b1100000;
         4'hC:    return 7'b0110001;
         4'hD:    return 7'b1000010;
         4'hE:    return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Update port of the scan controller: valid/ready handshake plus the
// full set of per-digit display fields captured on acceptance.
interface sevenseg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 8,
   parameter int BRIGHT_W   = 4
);
   import sevenseg_pkg::*;

   logic                        i_upd_valid;
   logic                        o_upd_ready;
   logic [4*NUM_DIGITS-1:0]     i_hex;
   logic [SEG_W*NUM_DIGITS-1:0] i_raw;
   logic [NUM_DIGITS-1:0]       i_raw_mask;
   logic [NUM_DIGITS-1:0]       i_dp;
   logic [NUM_DIGITS-1:0]       i_en_mask;
   logic [BRIGHT_W-1:0]         i_bright;

   modport master (
      output i_upd_valid, i_hex, i_raw, i_raw_mask, i_dp, i_en_mask, i_bright,
      input  o_upd_ready
   );

   modport slave (
      input  i_upd_valid, i_hex, i_raw, i_raw_mask, i_dp, i_en_mask, i_bright,
      output o_upd_ready
   );

endinterface

// File: rtl/sevenseg_hex_decode.sv
// Combinational nibble-to-glyph decoder, active-low segments.
module sevenseg_hex_decode
   import sevenseg_pkg::*;
(
   input  logic [3:0] hex,
   output seg_t       seg
);

   assign seg = hex_to_seg_n(hex);

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with PWM brightness, guard
// blanking and a double-buffered field set swapped only at frame boundaries.
module sevenseg_scan_ctrl
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 10000,
   parameter int BRIGHT_W   = 4,
   parameter int GUARD      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   sevenseg_scan_ctrl_if.slave   bus,
   output logic [NUM_DIGITS-1:0] o_an,
   output seg_t                  o_seg,
   output logic                  o_dp,
   output logic                  o_frame_start
);

   localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PH_LEN = SCAN_DIV >> BRIGHT_W;
   localparam int SUB_W  = (PH_LEN > 1) ? $clog2(PH_LEN) : 1;

   typedef struct packed {
      logic [NUM_DIGITS-1:0][3:0]       hex;
      logic [NUM_DIGITS-1:0][SEG_W-1:0] raw;
      logic [NUM_DIGITS-1:0]            raw_mask;
      logic [NUM_DIGITS-1:0]            dp;
      logic [NUM_DIGITS-1:0]            en_mask;
      logic [BRIGHT_W-1:0]              bright;
   } disp_fields_t;

   disp_fields_t act, pend, upd;
   logic         pend_v;

   logic [SLOT_W-1:0]   slot_cnt;
   logic [DIG_W-1:0]    dig_idx;
   logic [SUB_W-1:0]    sub_cnt;
   logic [BRIGHT_W-1:0] phase;
   logic                slot_wrap, dig_wrap, sub_wrap, boundary;

   assign upd = '{hex:      bus.i_hex,
                  raw:      bus.i_raw,
                  raw_mask: bus.i_raw_mask,
                  dp:       bus.i_dp,
                  en_mask:  bus.i_en_mask,
                  bright:   bus.i_bright};

   assign bus.o_upd_ready = ~pend_v;

   assign slot_wrap = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
   assign dig_wrap  = (dig_idx == DIG_W'(NUM_DIGITS - 1));
   assign sub_wrap  = (sub_cnt == SUB_W'(PH_LEN - 1));
   assign boundary  = slot_wrap & dig_wrap;

   // phase tracks slot_cnt / PH_LEN without a divider; it rolls over
   // exactly at slot wrap because SCAN_DIV = PH_LEN * 2**BRIGHT_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt <= '0;
         dig_idx  <= '0;
         sub_cnt  <= '0;
         phase    <= '0;
      end else begin
         slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
         sub_cnt  <= sub_wrap ? '0 : sub_cnt + 1'b1;
         if (sub_wrap)
            phase <= phase + 1'b1;
         if (slot_wrap)
            dig_idx <= dig_wrap ? '0 : dig_idx + 1'b1;
      end
   end

   // pend_v blocks acceptance, so swap and capture never coincide.
   always_ff @(posedge clk) begin
      if (rst) begin
         act    <= '0;
         pend   <= '0;
         pend_v <= 1'b0;
      end else if (boundary && pend_v) begin
         act    <= pend;
         pend_v <= 1'b0;
      end else if (bus.i_upd_valid && !pend_v) begin
         pend   <= upd;
         pend_v <= 1'b1;
      end
   end

   seg_t                  dec_seg, seg_val;
   logic                  lit;
   logic [NUM_DIGITS-1:0] an_onehot;

   sevenseg_hex_decode u_dec (
      .hex (act.hex[dig_idx]),
      .seg (dec_seg)
   );

   assign lit = act.en_mask[dig_idx]
              && (slot_cnt >= SLOT_W'(GUARD))
              && ((&act.bright) || (phase < act.bright));

   assign seg_val   = act.raw_mask[dig_idx] ? ~act.raw[dig_idx] : dec_seg;
   assign an_onehot = NUM_DIGITS'(1) << dig_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         o_an          <= '1;
         o_seg         <= '1;
         o_dp          <= 1'b1;
         o_frame_start <= 1'b0;
      end else begin
         o_frame_start <= (slot_cnt == '0) && (dig_idx == '0);
         if (lit) begin
            o_an  <= ~an_onehot;
            o_seg <= seg_val;
            o_dp  <= ~act.dp[dig_idx];
         end else begin
            o_an  <= '1;
            o_seg <= '1;
            o_dp  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Randomised and directed bench for sevenseg_scan_ctrl against a frame-position
// reference model (4 digits, 16-cycle slots, 2-bit brightness, 1 guard cycle).
module tb_sevenseg_scan_ctrl;

   localparam int ND = 4, SD = 16, BW = 2, GD = 1;
   localparam int FRAME = ND * SD;

   typedef struct packed {
      logic [15:0] hex;
      logic [27:0] raw;
      logic [3:0]  rm;
      logic [3:0]  dp;
      logic [3:0]  en;
      logic [1:0]  br;
   } f_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] o_an;
   logic [6:0] o_seg;
   logic       o_dp, o_frame_start;

   int vectors = 0, miscompares = 0, cyc = 0;
   f_t m_act = '0, m_pen = '0;
   logic m_pv = 1'b0;

   logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   sevenseg_scan_ctrl_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus ();

   sevenseg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BRIGHT_W(BW), .GUARD(GD)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .o_an          (o_an),
      .o_seg         (o_seg),
      .o_dp          (o_dp),
      .o_frame_start (o_frame_start)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d observed=timeout required=finish", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   // One clock: predict outputs from the frame position, advance the model, compare.
   task automatic step();
      int pos, d, s;
      logic lit;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic e_dp, e_fs;
      f_t in_f;
      in_f = '{hex: bus.i_hex, raw: bus.i_raw, rm: bus.i_raw_mask,
               dp: bus.i_dp, en: bus.i_en_mask, br: bus.i_bright};
      pos = cyc % FRAME;
      d = pos / SD;
      s = pos % SD;
      lit = m_act.en[d] && (s >= GD) && (m_act.br == 2'd3 || (s / (SD >> BW)) < int'(m_act.br));
      e_an  = lit ? (4'hF ^ (4'b0001 << d)) : 4'hF;
      e_seg = !lit ? 7'h7F : (m_act.rm[d] ? ~m_act.raw[d*7 +: 7] : seg_tab[m_act.hex[d*4 +: 4]]);
      e_dp  = lit ? ~m_act.dp[d] : 1'b1;
      e_fs  = (pos == 0);
      if (rst) begin
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
         m_act = '0; m_pen = '0; m_pv = 1'b0; cyc = 0;
      end else begin
         if (pos == FRAME - 1 && m_pv) begin
            m_act = m_pen;
            m_pv  = 1'b0;
         end else if (bus.i_upd_valid && !m_pv) begin
            m_pen = in_f;
            m_pv  = 1'b1;
         end
         cyc++;
      end
      @(posedge clk);
      #1;
      check("an", 32'(o_an), 32'(e_an));
      check("seg", 32'(o_seg), 32'(e_seg));
      check("dp", 32'(o_dp), 32'(e_dp));
      check("frame_start", 32'(o_frame_start), 32'(e_fs));
      check("upd_ready", 32'(bus.o_upd_ready), 32'(!m_pv));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_pos(input int p);
      for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != p; i++) step();
   endtask

   // Holds valid until the DUT shows ready before an edge, bounded.
   task automatic send(input f_t f);
      logic r, done;
      done = 1'b0;
      bus.i_hex = f.hex; bus.i_raw = f.raw; bus.i_raw_mask = f.rm;
      bus.i_dp = f.dp; bus.i_en_mask = f.en; bus.i_bright = f.br;
      bus.i_upd_valid = 1'b1;
      for (int k = 0; k < 3 * FRAME && !done; k++) begin
         r = bus.o_upd_ready;
         step();
         done = r;
      end
      bus.i_upd_valid = 1'b0;
      check("accept_timeout", 32'(done), 32'd1);
   endtask

   function automatic f_t rnd_f();
      f_t f;
      f.hex = 16'($urandom);
      f.raw = 28'($urandom);
      f.rm  = 4'($urandom);
      f.dp  = 4'($urandom);
      f.en  = 4'($urandom);
      f.br  = 2'($urandom);
      return f;
   endfunction

   initial begin
      f_t f;
      bus.i_upd_valid = 1'b0;
      bus.i_hex = '0; bus.i_raw = '0; bus.i_raw_mask = '0;
      bus.i_dp = '0; bus.i_en_mask = '0; bus.i_bright = '0;

      rst = 1'b1;
      run(3);
      rst = 1'b0;
      run(FRAME + 6);

      // Full brightness hex 8421.
      f = '{hex: 16'h8421, raw: '0, rm: 4'h0, dp: 4'h0, en: 4'hF, br: 2'd3};
      send(f);
      run(2 * FRAME);

      f.br = 2'd1;
      send(f);
      run(FRAME + FRAME / 2);
      f.br = 2'd0;
      send(f);
      run(FRAME + 4);

      // Raw digit 1 with DP, digit 2 masked off.
      f = '{hex: 16'h5A3C, raw: 28'h0, rm: 4'b0010, dp: 4'b0010, en: 4'b1011, br: 2'd3};
      f.raw[13:7] = 7'b1000000;
      send(f);
      run(2 * FRAME);

      // Mid-frame update, then a second one held while pending is full.
      wait_pos(2);
      send(rnd_f());
      send(rnd_f());
      run(FRAME);

      for (int i = 0; i < 8; i++) begin
         run($urandom_range(0, 90));
         send(rnd_f());
      end
      run(2 * FRAME);

      // Reset at digit 2 slot 7 with an update still pending.
      f = rnd_f();
      f.en = 4'hF;
      f.br = 2'd3;
      wait_pos(2);
      send(f);
      wait_pos(2 * SD + 7);
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      run(FRAME + 8);
      send(rnd_f());
      run(2 * FRAME);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
